// File: rtl/crc_scrambler_pkg.sv
// SATA link-layer constants and helpers.
// CRC32 / scrambler column tables for the parallel datapaths.
package crc_scrambler_pkg;

  localparam logic [31:0] SATA_CRC_INIT = 32'h5232_5032;
  localparam logic [31:0] SATA_CRC_POLY = 32'h04C1_1DB7;

  // x^16 + x^15 + x^13 + x^4 + 1, x^16 implicit
  localparam logic [15:0] SCR_POLY  = 16'hA011;
  localparam logic [15:0] SCR_SEED  = 16'hFFFF;
  localparam logic [31:0] SCR_WORD0 = 32'hC2D2_768D;

  typedef enum logic [31:0] {
    P_ALIGN = 32'h7B4A_4ABC,
    P_SOF   = 32'h3737_B57C,
    P_EOF   = 32'hD5D5_B57C
  } sata_prim_e;

  typedef logic [31:0][31:0] mat32_t;
  typedef logic [15:0][31:0] scr_wmat_t;
  typedef logic [15:0][15:0] scr_smat_t;

  function automatic logic [31:0] crc_step32(
    input logic [31:0] crc,
    input logic [31:0] data,
    input logic [31:0] poly
  );
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
    end
    return c;
  endfunction

  // column j = contribution of crc[j] (or data[j]) alone
  function automatic mat32_t crc_cols(
    input logic [31:0] poly,
    input logic        on_data
  );
    mat32_t m;
    for (int j = 0; j < 32; j++) begin
      if (on_data)
        m[j] = crc_step32(32'h0, 32'h1 << j, poly);
      else
        m[j] = crc_step32(32'h1 << j, 32'h0, poly);
    end
    return m;
  endfunction

  function automatic logic [31:0] mul32(
    input mat32_t      m,
    input logic [31:0] v
  );
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 32; j++)
      if (v[j]) r = r ^ m[j];
    return r;
  endfunction

  // 32 Galois steps; output bit i is state[15] before step i
  function automatic logic [31:0] scr_word32(
    input logic [15:0] s
  );
    logic [15:0] st;
    logic [31:0] w;
    st = s;
    for (int i = 0; i < 32; i++) begin
      w[i] = st[15];
      st = {st[14:0], 1'b0} ^ (st[15] ? SCR_POLY : 16'h0);
    end
    return w;
  endfunction

  function automatic logic [15:0] scr_state32(
    input logic [15:0] s
  );
    logic [15:0] st;
    st = s;
    for (int i = 0; i < 32; i++)
      st = {st[14:0], 1'b0} ^ (st[15] ? SCR_POLY : 16'h0);
    return st;
  endfunction

  function automatic scr_wmat_t scr_wcols();
    scr_wmat_t m;
    for (int j = 0; j < 16; j++)
      m[j] = scr_word32(16'h1 << j);
    return m;
  endfunction

  function automatic scr_smat_t scr_scols();
    scr_smat_t m;
    for (int j = 0; j < 16; j++)
      m[j] = scr_state32(16'h1 << j);
    return m;
  endfunction

  function automatic logic [31:0] mul16x32(
    input scr_wmat_t   m,
    input logic [15:0] v
  );
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      if (v[j]) r = r ^ m[j];
    return r;
  endfunction

  function automatic logic [15:0] mul16(
    input scr_smat_t   m,
    input logic [15:0] v
  );
    logic [15:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      if (v[j]) r = r ^ m[j];
    return r;
  endfunction

endpackage

// File: rtl/crc_scrambler_if.sv
// Dword bus between the link FIFO side and crc_scrambler.
// Master feeds Dwords, slave returns CRC and scrambler word.
interface crc_scrambler_if;
  logic        data_valid;
  logic [31:0] data_in;
  logic [31:0] crc_out;
  logic [31:0] scrambler;

  modport master (
    output data_valid,
    output data_in,
    input  crc_out,
    input  scrambler
  );

  modport slave (
    input  data_valid,
    input  data_in,
    output crc_out,
    output scrambler
  );
endinterface

// File: rtl/sata_scr_lfsr.sv
// SATA scrambler: 16-bit Galois LFSR, 32 steps per Dword.
// word holds the scrambler word for the current Dword.
module sata_scr_lfsr
  import crc_scrambler_pkg::*;
#(
  parameter logic [31:0] FIRST_WORD = SCR_WORD0,
  parameter logic [15:0] SEED       = SCR_SEED
) (
  input  logic        clk_75m,
  input  logic        restart,
  input  logic        advance,
  output logic [31:0] word
);

  // FIRST_WORD is the output of SEED; state then sits one word ahead
  localparam logic [15:0] STATE1 = scr_state32(SEED);
  localparam scr_wmat_t   W_M    = scr_wcols();
  localparam scr_smat_t   S_M    = scr_scols();

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic [31:0] word_q;
  logic [31:0] word_d;

  // parallel 32-step output and next-state matrices
  always_comb begin
    word_d  = mul16x32(W_M, state_q);
    state_d = mul16(S_M, state_q);
  end

  // restart wins; otherwise step once per accepted Dword
  always_ff @(posedge clk_75m) begin
    if (restart) begin
      state_q <= STATE1;
      word_q  <= FIRST_WORD;
    end else if (advance) begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/crc_scrambler.sv
// SATA link CRC32 and scrambler word generator.
// Both sequences restart together on crc_rst.
module crc_scrambler
  import crc_scrambler_pkg::*;
#(
  parameter logic [31:0] CRC_INIT  = SATA_CRC_INIT,
  parameter logic [31:0] CRC_POLY  = SATA_CRC_POLY,
  parameter logic [31:0] SCR_FIRST = SCR_WORD0
) (
  input  logic          clk_75m,
  input  logic          crc_rst,
  crc_scrambler_if.slave bus
);

  localparam mat32_t CRC_MC = crc_cols(CRC_POLY, 1'b0);
  localparam mat32_t CRC_MD = crc_cols(CRC_POLY, 1'b1);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // one Dword of MSB-first CRC as a linear XOR matrix
  always_comb begin
    crc_d = mul32(CRC_MC, crc_q)
          ^ mul32(CRC_MD, bus.data_in);
  end

  // restart beats accept; idle holds
  always_ff @(posedge clk_75m) begin
    if (crc_rst)
      crc_q <= CRC_INIT;
    else if (bus.data_valid)
      crc_q <= crc_d;
  end

  assign bus.crc_out = crc_q;

  sata_scr_lfsr #(
    .FIRST_WORD (SCR_FIRST)
  ) u_scr (
    .clk_75m (clk_75m),
    .restart (crc_rst),
    .advance (bus.data_valid),
    .word    (bus.scrambler)
  );

endmodule

// File: tb/tb_crc_scrambler.sv
// Directed and random checks of crc_scrambler
// against a bit-serial CRC/LFSR model.
module tb_crc_scrambler;

  localparam logic [31:0] INIT = 32'h5232_5032;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] W0   = 32'hC2D2_768D;

  logic clk_75m = 1'b0;
  logic crc_rst = 1'b0;

  crc_scrambler_if bus();

  crc_scrambler dut (
    .clk_75m (clk_75m),
    .crc_rst (crc_rst),
    .bus     (bus)
  );

  always #7 clk_75m = ~clk_75m;

  int checks = 0;
  int fails  = 0;

  logic [31:0] m_crc;
  logic [31:0] m_scr;
  logic [15:0] m_lfsr;

  logic [31:0] scr_hand [4] = '{
    32'hC2D2_768D, 32'h1F26_B368,
    32'hA508_436C, 32'h3452_D354};
  logic [31:0] dat4 [4] = '{
    32'h0000_0000, 32'hFFFF_FFFF,
    32'h1234_5678, 32'h8000_0001};
  logic [31:0] fis [5] = '{
    32'h00EC_8027, 32'hA000_0000,
    32'h0000_0000, 32'h0000_0001,
    32'h0000_0000};

  logic [31:0] crc4 [4];
  logic [31:0] fis_crc [5];
  logic [31:0] fis_scr [6];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(
    input logic [31:0] c,
    input logic [31:0] d
  );
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  task automatic scr_take();
    for (int i = 0; i < 32; i++) begin
      m_scr[i] = m_lfsr[15];
      if (m_lfsr[15]) m_lfsr = (m_lfsr << 1) ^ 16'hA011;
      else            m_lfsr = m_lfsr << 1;
    end
  endtask

  task automatic drive(
    input logic        r,
    input logic        v,
    input logic [31:0] d
  );
    crc_rst        = r;
    bus.data_valid = v;
    bus.data_in    = d;
  endtask

  task automatic tick();
    if (crc_rst) begin
      m_crc  = INIT;
      m_lfsr = 16'hFFFF;
      scr_take();
    end else if (bus.data_valid) begin
      m_crc = ref_crc(m_crc, bus.data_in);
      scr_take();
    end
    @(posedge clk_75m);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    logic        v;

    // reset then idle: both registers constant
    drive(1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < 6; i++) begin
      check("rst_crc", bus.crc_out, INIT);
      check("rst_scr", bus.scrambler, W0);
      if (i < 5) tick();
    end

    // back-to-back accepts
    drive(1'b1, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, dat4[k]);
      check("b2b_scr", bus.scrambler, scr_hand[k]);
      tick();
      crc4[k] = m_crc;
      check("b2b_crc", bus.crc_out, m_crc);
    end
    check("b2b_scr4", bus.scrambler, m_scr);

    // same Dwords with gaps of 1..3 cycles
    drive(1'b1, 1'b0, 32'h0);
    tick();
    prev = INIT;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 1 + (k % 3); g++) begin
        drive(1'b0, 1'b0, $urandom);
        check("gap_scr", bus.scrambler, scr_hand[k]);
        check("gap_crc", bus.crc_out, prev);
        tick();
      end
      drive(1'b0, 1'b1, dat4[k]);
      check("gapv_scr", bus.scrambler, scr_hand[k]);
      tick();
      check("gapv_crc", bus.crc_out, crc4[k]);
      prev = crc4[k];
    end

    // random data/valid, runs past one LFSR period
    drive(1'b1, 1'b0, 32'h0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      drive(1'b0, v, $urandom);
      tick();
      if (v) begin
        check("rnd_crc", bus.crc_out, m_crc);
        check("rnd_scr", bus.scrambler, m_scr);
      end
    end

    // restart with simultaneous valid
    drive(1'b1, 1'b1, $urandom);
    tick();
    check("rstv_crc", bus.crc_out, INIT);
    check("rstv_scr", bus.scrambler, W0);

    // H2D FIS sent as two frames
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 5; k++) begin
        drive(1'b0, 1'b1, fis[k]);
        if (f == 0) fis_scr[k] = m_scr;
        check("fis_scr", bus.scrambler, fis_scr[k]);
        if (k < 4)
          check("fis_hscr", bus.scrambler, scr_hand[k]);
        tick();
        if (f == 0) fis_crc[k] = m_crc;
        check("fis_crc", bus.crc_out, fis_crc[k]);
      end
      drive(1'b0, 1'b0, 32'h0);
      if (f == 0) fis_scr[5] = m_scr;
      check("fis_eof_scr", bus.scrambler, fis_scr[5]);
      check("fis_final", bus.crc_out,
            ref_crc(ref_crc(ref_crc(ref_crc(
              ref_crc(INIT, fis[0]), fis[1]),
              fis[2]), fis[3]), fis[4]));
      drive(1'b1, 1'b0, 32'h0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/crc_scrambler.md
# crc_scrambler

SATA Link-layer transmit/receive datapath helper. Each clock it delivers the 32-bit scrambler word for the current Dword and the running CRC32 over every Dword accepted since the last restart. The CRC and scrambler sequences restart together at each frame boundary. The block sits beside the Transport-to-Link FIFO: the parent XORs `data_in` with `scrambler`, and on the last Dword of a frame XORs `crc_out` with `scrambler`.

## Interface
- `CRC_INIT`, default 32'h5232_5032: CRC register value after restart (SATA CRC seed).
- `CRC_POLY`, default 32'h04C1_1DB7: CRC generator polynomial, non-reflected.
- `SCR_FIRST`, default 32'hC2D2_768D: first scrambler word after restart. It fixes the LFSR seed.

Ports (one clock; reset is synchronous and active-high):
- `clk_75m`  in  1  clock; all state changes on its rising edge.
- `crc_rst`  in  1  synchronous active-high reset/restart of both CRC and scrambler.
- `data_valid`  in  1  the current Dword is accepted; advances the CRC and the scrambler.
- `data_in`  in  32  Dword fed to the CRC (unscrambled payload).
- `crc_out`  out  32  registered CRC over all accepted Dwords.
- `scrambler`  out  32  registered scrambler word to apply to the current Dword.

## Operation
- CRC:
  - 32-bit register, MSB-first, non-reflected.
  - No input or output inversion, no byte swapping.
  - On accept, for i = 31 down to 0: fb = crc[31] ^ data_in[i]; crc = {crc[30:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - Implement as a single-cycle parallel 32-bit XOR matrix.
- Scrambler:
  - 16-bit Galois LFSR, G(x) = x^16 + x^15 + x^13 + x^4 + 1.
  - Advances 32 bit-steps per accepted Dword; the 32 output bits form one word.
  - Bit ordering and seed are fixed by the required sequence: 0xC2D2768D, 0x1F26B368, 0xA508436C, 0x3452D354 (words 0..3 after restart).
  - Output and next-state logic are single-cycle parallel XOR matrices.
- Restart:
  - `crc_rst`=1 loads crc = CRC_INIT and scrambler = word 0 (SCR_FIRST).
  - Restart has priority over a simultaneous `data_valid`.
- Idle: `data_valid`=0 and `crc_rst`=0 hold both registers unchanged.
- Scrambling is independent of data content. The same sequence is used for payload and CRC Dwords.

## Timing
- Reset values: `crc_out`=0x52325032, `scrambler`=0xC2D2768D, visible in the cycle after `crc_rst` is sampled high.
- `scrambler` is valid combinationally for the Dword presented in the same cycle. It advances one step on each edge where `data_valid`=1.
- `crc_out` has one-cycle latency: after the edge that accepts Dword n, it covers Dwords 0..n.
- Frame sequence:
  - After the last payload Dword is accepted, `crc_out` is the final frame CRC.
  - `scrambler` then holds word N (N = payload Dword count), which the parent XORs with `crc_out` for the CRC Dword.
  - The parent asserts `crc_rst` afterwards.
- Back-to-back `data_valid` every cycle is supported with no bubbles.
- Gaps (`data_valid` low) at any point are supported; state is held during a gap.
- Reset mid-frame discards all state; the next accepted Dword is treated as Dword 0.
- No wrap limit: the scrambler period is 2^16−1 bit-steps. Frames longer than one period continue the sequence naturally.

## Structure
- Shared SATA package holds CRC_INIT, CRC_POLY, scrambler polynomial/seed and the primitive constants (P_ALIGN, P_SOF, P_EOF).
- Sub-module `sata_scr_lfsr`: the 16-bit LFSR with a 32-step parallel next/output function.
- The CRC is a parallel-update function inline in `crc_scrambler`.
- Total RTL size target: ~150–250 lines.

## Test plan
- Assert `crc_rst` for one cycle, then idle 5 cycles -> `crc_out`=0x52325032, `scrambler`=0xC2D2768D, both constant.
- `crc_rst`, then `data_valid`=1 for 4 cycles -> `scrambler` shows 0xC2D2768D, 0x1F26B368, 0xA508436C, 0x3452D354 in successive cycles.
- Same 4 accepts with `data_valid` gaps of 1–3 cycles between them -> identical scrambler and CRC sequences; values hold during gaps.
- 1 000 random Dwords, random `data_valid` -> `crc_out` matches the bit-serial reference model after every accept. Also check a 5-Dword Register H2D FIS against the value computed by the bit-serial model.
- `crc_rst` and `data_valid` high in the same cycle mid-frame -> next cycle `crc_out`=0x52325032, `scrambler`=0xC2D2768D.
- Two back-to-back frames with `crc_rst` between them -> the second frame's CRC and scrambler words are identical to those of the same data sent as a first frame.
